pipe_if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, computes next-PC from the ID stage's `pcsource`, and runs a req/ready fetch against instruction memory. It feeds the IF/ID pipeline register (`dpc4`, `dinst`, `dvalid`) that the ID control unit decodes. It also absorbs ID stalls (`nostall`) and memory wait states without losing the branch delay slot or a pending control transfer.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_if_stage_if.sv | 10 +
 rtl/pipe_ifid_reg.sv | 83 ++++++++
 rtl/pipe_if_stage.sv | 112 +++++++++++
 tb/tb_pipe_if_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS fetch pipeline: next-PC selector encoding,
// bubble encoding and reset vector.
package pipe_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sequential successor; the 32-bit sum wraps 32'hFFFF_FFFC to zero.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc_val);
        return pc_val + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
interface pipe_if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer that catches an
// instruction fetched while ID is stalled.
module pipe_ifid_reg
    import pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        fire_i,
    input  logic        nostall_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] dpc4_o,
    output logic [31:0] dinst_o,
    output logic        dvalid_o,
    output logic        hold_valid_o
);

    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] dinst_q, dinst_d;
    logic        dvalid_q, dvalid_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    // Next-state selection for IF/ID and hold buffer.
    always_comb begin
        dpc4_d       = dpc4_q;
        dinst_d      = dinst_q;
        dvalid_d     = dvalid_q;
        hold_valid_d = hold_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc4_d   = hold_pc4_q;
        if (nostall_i) begin
            if (hold_valid_q) begin
                dinst_d      = hold_inst_q;
                dpc4_d       = hold_pc4_q;
                dvalid_d     = 1'b1;
                hold_valid_d = 1'b0;
            end else if (fire_i) begin
                dinst_d  = rdata_i;
                dpc4_d   = pc4_i;
                dvalid_d = 1'b1;
            end else begin
                dinst_d  = NOP_INST;
                dvalid_d = 1'b0;
            end
        end else begin
            // ID frozen: a fetch completing now must be parked, not dropped.
            if (fire_i) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = rdata_i;
                hold_pc4_d   = pc4_i;
            end else begin
                hold_valid_d = hold_valid_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            dpc4_q       <= 32'h0000_0000;
            dinst_q      <= NOP_INST;
            dvalid_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= 32'h0000_0000;
            hold_pc4_q   <= 32'h0000_0000;
        end else begin
            dpc4_q       <= dpc4_d;
            dinst_q      <= dinst_d;
            dvalid_q     <= dvalid_d;
            hold_valid_q <= hold_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    assign dpc4_o       = dpc4_q;
    assign dinst_o      = dinst_q;
    assign dvalid_o     = dvalid_q;
    assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/pipe_if_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection with delayed-branch
// semantics, redirect tracking across memory wait states, and IF/ID feed.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    nostall,
    input  logic [1:0]              pcsource,
    input  logic [31:0]             bpc,
    input  logic [31:0]             da,
    input  logic [31:0]             jpc,
    pipe_if_stage_if.master         imem,
    output logic [31:0]             pc,
    output logic [31:0]             dpc4,
    output logic [31:0]             dinst,
    output logic                    dvalid
);

    logic [31:0] pc_q, pc_d;
    logic        redir_pending_q, redir_pending_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        hold_valid_s;
    logic        dvalid_s;
    logic        req_s;
    logic        fire_s;
    logic        take_s;
    logic [31:0] target_s;
    logic [31:0] pc4_s;
    pcsrc_e      src_s;

    assign src_s  = pcsrc_e'(pcsource);
    assign pc4_s  = pc_plus4(pc_q);
    assign req_s  = ~reset & ~hold_valid_s;
    assign fire_s = req_s & imem.imem_ready;
    assign take_s = dvalid_s & nostall & (src_s != PCSRC_SEQ);

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_q;

    // Control-transfer target selection.
    always_comb begin
        target_s = pc4_s;
        case (src_s)
            PCSRC_BR: target_s = bpc;
            PCSRC_JR: target_s = da;
            PCSRC_J:  target_s = jpc;
            default:  target_s = pc4_s;
        endcase
    end

    // PC / redirect next state. The fetch in flight when a transfer sits in
    // ID is its delay slot, so a transfer that cannot steer the PC yet is
    // remembered until that slot has been fetched.
    always_comb begin
        pc_d            = pc_q;
        redir_pending_d = redir_pending_q;
        redir_pc_d      = redir_pc_q;
        if (fire_s) begin
            if (redir_pending_q) begin
                pc_d            = redir_pc_q;
                redir_pending_d = 1'b0;
            end else if (take_s) begin
                pc_d = target_s;
            end else begin
                pc_d = pc4_s;
            end
        end else if (take_s) begin
            if (hold_valid_s) begin
                pc_d = target_s;
            end else begin
                redir_pending_d = 1'b1;
                redir_pc_d      = target_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and redirect registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            redir_pending_q <= 1'b0;
            redir_pc_q      <= 32'h0000_0000;
        end else begin
            pc_q            <= pc_d;
            redir_pending_q <= redir_pending_d;
            redir_pc_q      <= redir_pc_d;
        end
    end

    pipe_ifid_reg u_ifid (
        .clock        (clock),
        .reset        (reset),
        .fire_i       (fire_s),
        .nostall_i    (nostall),
        .rdata_i      (imem.imem_rdata),
        .pc4_i        (pc4_s),
        .dpc4_o       (dpc4),
        .dinst_o      (dinst),
        .dvalid_o     (dvalid_s),
        .hold_valid_o (hold_valid_s)
    );

    assign dvalid = dvalid_s;
    assign pc     = pc_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Scoreboard bench for pipe_if_stage: directed per-cycle vectors drive the
// stage; a monitor checks every instruction ID consumes against an expected queue.
module tb_pipe_if_stage;
    import pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        nostall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc;
    logic [31:0] pc, dpc4, dinst;
    logic        dvalid;

    pipe_if_stage_if imem ();

    pipe_if_stage dut (
        .clock    (clock),
        .reset    (reset),
        .nostall  (nostall),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .imem     (imem),
        .pc       (pc),
        .dpc4     (dpc4),
        .dinst    (dinst),
        .dvalid   (dvalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    assign imem.imem_rdata = imem.imem_ready ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        ns;
        logic        rdy;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic        chk;
        logic [31:0] epc;
        logic        ereq;
    } row_t;

    exp_t sb_q[$];
    row_t rows[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t mk(input logic rst, input logic ns, input logic rdy,
                                input logic [1:0] src, input logic [31:0] tgt,
                                input logic chk, input logic [31:0] epc, input logic ereq);
        row_t r;
        r.rst = rst; r.ns = ns; r.rdy = rdy; r.src = src; r.tgt = tgt;
        r.chk = chk; r.epc = epc; r.ereq = ereq;
        return r;
    endfunction

    // Monitor: each cycle ID accepts a valid instruction, compare with the queue head.
    always @(negedge clock) begin
        if (mon_en && dvalid === 1'b1 && nostall === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_inst: got %h with pc4 %h, queue empty", dinst, dpc4);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("dinst", dinst, e.inst);
                check("dpc4", dpc4, e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addrs [20];
        exp_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h44,
                      32'h48, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h210,
                      32'h1000, 32'h1004, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4};
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            e.inst = mem_word(exp_addrs[i]);
            e.pc4  = exp_addrs[i] + 32'd4;
            sb_q.push_back(e);
        end

        //          rst   ns    rdy   src    tgt            chk   pc             req
        rows.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        1'b0, 32'h0,         1'b0));
        rows.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h0,         1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h0,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h4,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h8,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'hC,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h10,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 32'h40,       1'b1, 32'h14,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h40,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h44,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h200,      1'b1, 32'h48,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h48,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h48,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h48,        1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h200,       1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1, 32'h204,       1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1, 32'h208,       1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h208,       1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h208,       1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h20C,       1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1, 32'h210,       1'b1));
        rows.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1, 32'h214,       1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 32'h1000,     1'b1, 32'h214,       1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h1000,      1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFC, 1'b1, 32'h1004,     1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h0,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 32'h80,       1'b1, 32'h4,         1'b1));
        rows.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h4,         1'b0));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h0,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h4,         1'b1));
        rows.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b1, 32'h8,         1'b1));
        rows.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1, 32'hC,         1'b0));
        rows.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1, 32'h0,         1'b0));

        reset = 1'b1; nostall = 1'b1; pcsource = 2'd0;
        bpc = 32'h0; da = 32'h0; jpc = 32'h0;
        imem.imem_ready = 1'b1;

        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clock);
            #1;
            reset           = rows[i].rst;
            nostall         = rows[i].ns;
            imem.imem_ready = rows[i].rdy;
            pcsource        = rows[i].src;
            // Only the selected source carries the real target.
            bpc = (rows[i].src == 2'd1) ? rows[i].tgt : (rows[i].tgt ^ 32'h0000_0F00);
            da  = (rows[i].src == 2'd2) ? rows[i].tgt : (rows[i].tgt ^ 32'h0000_F000);
            jpc = (rows[i].src == 2'd3) ? rows[i].tgt : (rows[i].tgt ^ 32'h000F_0000);
            #1;
            if (rows[i].chk) begin
                check($sformatf("pc_row%0d", i), pc, rows[i].epc);
                check($sformatf("imem_addr_row%0d", i), imem.imem_addr, rows[i].epc);
                check($sformatf("imem_req_row%0d", i), {31'h0, imem.imem_req}, {31'h0, rows[i].ereq});
            end
            if (i == 1) begin
                check("reset_dvalid", {31'h0, dvalid}, 32'h0);
                check("reset_dinst", dinst, NOP_INST);
                check("reset_dpc4", dpc4, 32'h0);
                mon_en = 1'b1;
            end
        end

        check("final_dvalid", {31'h0, dvalid}, 32'h0);
        check("final_dinst", dinst, NOP_INST);
        @(negedge clock);
        @(negedge clock);
        check("sb_leftover", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
